// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - borrow_in, LSB first, one full-subtractor cell
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             accept;
    logic [WIDTH-1:0] a_sr, b_sr, diff_r;
    logic [CW-1:0]    cnt;
    logic             bw, borrow_out_r;
    logic             x, y, d, bw_next;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                // start seen in DONE is accepted immediately for back-to-back ops
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        x       = a_sr[0];
        y       = b_sr[0];
        d       = x ^ y ^ bw;
        bw_next = (~x & y) | (~(x ^ y) & bw);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            diff_r       <= '0;
            bw           <= 1'b0;
            cnt          <= '0;
            borrow_out_r <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sr <= bus.a;
                b_sr <= bus.b;
                bw   <= bus.borrow_in;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                diff_r <= (diff_r >> 1) | (WIDTH'(d) << (WIDTH - 1));
                bw     <= bw_next;
                cnt    <= cnt + CW'(1);
                // published on the last bit so it is valid during the done cycle
                if (cnt == LAST) borrow_out_r <= bw_next;
            end
        end
    end

    assign bus.busy       = (state == SHIFT);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_out_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed checks of serial_subtractor at WIDTH=8 and WIDTH=1
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Busy for 8 cycles after the accepting edge, done on the 9th.
    task automatic wait_result8(input logic [7:0] ed, input logic eb, input string tag);
        for (int i = 1; i <= 8; i++) begin
            check({tag, " busy"}, 32'(bus8.busy), 32'd1);
            check({tag, " done_early"}, 32'(bus8.done), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, " done"}, 32'(bus8.done), 32'd1);
        check({tag, " busy_in_done"}, 32'(bus8.busy), 32'd0);
        check({tag, " diff"}, 32'(bus8.diff), 32'(ed));
        check({tag, " borrow_out"}, 32'(bus8.borrow_out), 32'(eb));
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb, input string tag);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.borrow_in = bi;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.a = 'x; bus8.b = 'x; bus8.borrow_in = 1'bx;
        wait_result8(ed, eb, tag);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(bus8.done), 32'd0);
        check({tag, " diff_hold"}, 32'(bus8.diff), 32'(ed));
    endtask

    task automatic op1(input logic a, input logic b, input logic bi,
                       input logic ed, input logic eb, input string tag);
        @(negedge clk);
        bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.borrow_in = bi;
        @(posedge clk); #1;
        bus1.start = 1'b0; bus1.a = 'x; bus1.b = 'x; bus1.borrow_in = 1'bx;
        check({tag, " busy"}, 32'(bus1.busy), 32'd1);
        check({tag, " done_early"}, 32'(bus1.done), 32'd0);
        @(posedge clk); #1;
        check({tag, " done"}, 32'(bus1.done), 32'd1);
        check({tag, " diff"}, 32'(bus1.diff), 32'(ed));
        check({tag, " borrow_out"}, 32'(bus1.borrow_out), 32'(eb));
        @(posedge clk); #1;
    endtask

    // Full-subtractor truth table indexed by {a,b,borrow_in}: {borrow, diff}
    logic [1:0] fs_table [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    initial begin
        logic [7:0] ra, rb;
        logic       rbi;
        logic [8:0] ref9;
        int         seen_done;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.borrow_in = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.borrow_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus8.busy), 32'd0);
        check("reset done", 32'(bus8.done), 32'd0);
        check("reset diff", 32'(bus8.diff), 32'd0);
        check("reset borrow_out", 32'(bus8.borrow_out), 32'd0);
        @(negedge clk); rst = 1'b0;

        op8(8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, "t1");

        // back-to-back: start held high through SHIFT with new operands on the bus
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h01; bus8.borrow_in = 1'b0;
        @(posedge clk); #1;
        bus8.a = 8'hFF; bus8.b = 8'hFF;
        wait_result8(8'h7F, 1'b0, "t3a");
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.a = 'x; bus8.b = 'x; bus8.borrow_in = 1'bx;
        wait_result8(8'h00, 1'b0, "t3b");
        @(posedge clk); #1;
        check("t3 done_pulse", 32'(bus8.done), 32'd0);

        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t2a");
        op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, "t2b");

        // reset during the 4th SHIFT cycle aborts the operation
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h33; bus8.borrow_in = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t4 busy_before_rst", 32'(bus8.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4 busy", 32'(bus8.busy), 32'd0);
        check("t4 done", 32'(bus8.done), 32'd0);
        check("t4 diff", 32'(bus8.diff), 32'd0);
        check("t4 borrow_out", 32'(bus8.borrow_out), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen_done++;
        end
        check("t4 no_done_after_abort", 32'(seen_done), 32'd0);
        op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "t4c");

        for (int n = 0; n < 300; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbi  = 1'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            op8(ra, rb, rbi, ref9[7:0], ref9[8], "rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        for (int k = 0; k < 8; k++) begin
            logic [2:0] idx;
            idx = 3'(k);
            op1(idx[2], idx[1], idx[0], fs_table[k][0], fs_table[k][1], "w1");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
